// File: rtl/dmem_port_arbiter.sv
// Dual-lane load/store arbiter for the single-port data memory.
// Requests are accepted in program order, one per cycle, with 3-edge load latency.
module dmem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_isld,
  input  logic                    req0_isst,
  input  logic [DATA_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_wdata,
  input  logic [TAG_W-1:0]        req0_rd,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_isld,
  input  logic                    req1_isst,
  input  logic [DATA_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_wdata,
  input  logic [TAG_W-1:0]        req1_rd,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    resp_valid,
  output logic                    resp_lane,
  output logic [DATA_W+TAG_W-1:0] resp_rdval,
  output logic                    addr_err,
  output logic                    busy
);

  logic              pend1_q, pend1_d;
  logic              a_vld_q, a_vld_d;
  logic              a_ld_q, a_ld_d;
  logic              a_lane_q, a_lane_d;
  logic [TAG_W-1:0]  a_rd_q, a_rd_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              b_vld_q, b_vld_d;
  logic              b_lane_q, b_lane_d;
  logic [TAG_W-1:0]  b_rd_q, b_rd_d;
  logic              b_err_q, b_err_d;
  logic              rv_q, rv_d;
  logic              rl_q, rl_d;
  logic [DATA_W+TAG_W-1:0] rdv_q, rdv_d;

  logic              go, gnt0, gnt1, acc;
  logic              s_ld, s_st, s_oor;
  logic [DATA_W-1:0] s_addr, s_wdata;
  logic [TAG_W-1:0]  s_rd;

  always_comb begin
    go     = rst_n & ~flush;
    gnt0   = go & ~pend1_q & req0_valid;
    // A waiting lane 1 blocks any newer lane-0 op
    gnt1   = go & req1_valid & (pend1_q | ~req0_valid);
    acc    = gnt0 | gnt1;
    s_ld    = gnt0 ? req0_isld  : req1_isld;
    s_st    = (gnt0 ? req0_isst : req1_isst) & ~s_ld;
    s_addr  = gnt0 ? req0_addr  : req1_addr;
    s_wdata = gnt0 ? req0_wdata : req1_wdata;
    s_rd    = gnt0 ? req0_rd    : req1_rd;
    s_oor   = |s_addr[DATA_W-1:ADDR_W];

    pend1_d = pend1_q;
    if (flush || gnt1)
      pend1_d = 1'b0;
    else if (gnt0 && req1_valid)
      pend1_d = 1'b1;

    a_vld_d  = acc & (s_ld | s_st);
    a_ld_d   = acc & s_ld;
    a_lane_d = gnt1;
    a_rd_d   = s_rd;
    en_d     = acc & (s_ld | s_st) & ~s_oor;
    we_d     = acc & s_st & ~s_oor;
    addr_d   = s_addr[ADDR_W-1:0];
    wdata_d  = s_wdata;
    err_d    = acc & (s_ld | s_st) & s_oor;

    b_vld_d  = a_vld_q & a_ld_q & ~flush;
    b_lane_d = a_lane_q;
    b_rd_d   = a_rd_q;
    b_err_d  = err_q;

    rv_d  = b_vld_q & ~flush;
    rl_d  = rl_q;
    rdv_d = rdv_q;
    if (b_vld_q) begin
      rl_d  = b_lane_q;
      // Out-of-range loads return zero instead of stale read data
      rdv_d = {(b_err_q ? '0 : mem_rdata), b_rd_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1_q  <= 1'b0;
      a_vld_q  <= 1'b0;
      a_ld_q   <= 1'b0;
      a_lane_q <= 1'b0;
      a_rd_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      b_vld_q  <= 1'b0;
      b_lane_q <= 1'b0;
      b_rd_q   <= '0;
      b_err_q  <= 1'b0;
      rv_q     <= 1'b0;
      rl_q     <= 1'b0;
      rdv_q    <= '0;
    end else begin
      pend1_q  <= pend1_d;
      a_vld_q  <= a_vld_d;
      a_ld_q   <= a_ld_d;
      a_lane_q <= a_lane_d;
      a_rd_q   <= a_rd_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      b_vld_q  <= b_vld_d;
      b_lane_q <= b_lane_d;
      b_rd_q   <= b_rd_d;
      b_err_q  <= b_err_d;
      rv_q     <= rv_d;
      rl_q     <= rl_d;
      rdv_q    <= rdv_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mem_en     = en_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign addr_err   = err_q;
  assign resp_valid = rv_q;
  assign resp_lane  = rl_q;
  assign resp_rdval = rdv_q;
  assign busy       = a_vld_q | b_vld_q | rv_q;

endmodule
